// File: rtl/matrix_input_loader.sv
// matrix_input_loader
// Collects one matrix element-by-element over a valid/ready stream, assembles
// it row-major into a zero-padded MAX_DIM x MAX_DIM buffer, presents it on the
// storage write port and then completes the storage ready/release handshake.
//
// Element stream handshake: an element is transferred on a rising clock edge
// where elem_valid_i and elem_ready_o are both high. elem_ready_o is high only
// while collecting. elem_valid_i in any other state is ignored and consumes
// nothing. The producer may raise or drop elem_valid_i at any time.

module matrix_input_loader #(
    parameter int MAX_DIM = 5,
    parameter int ELEM_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start_i,
    input  logic                                           abort_i,
    input  logic [2:0]                                     rows_in_i,
    input  logic [2:0]                                     cols_in_i,
    input  logic [1:0]                                     id_in_i,
    input  logic                                           elem_valid_i,
    input  logic [ELEM_W-1:0]                              elem_data_i,
    output logic                                           elem_ready_o,
    output logic                                           write_en_o,
    output logic [2:0]                                     rows_out_o,
    output logic [2:0]                                     cols_out_o,
    output logic [1:0]                                     mat_id_out_o,
    output logic [0:MAX_DIM-1][0:MAX_DIM-1][ELEM_W-1:0]    data_out_o,
    input  logic                                           mem_ready_i,
    input  logic                                           mem_error_i,
    output logic [4:0]                                     elem_count_o,
    output logic                                           busy_o,
    output logic                                           done_o,
    output logic                                           error_o
);

    // Width of the WRITE-state wait counter; it counts 0 .. TIMEOUT-1.
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [2:0]        DIM_MAX   = 3'(MAX_DIM);
    localparam logic [1:0]        ID_MAX    = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    typedef logic [0:MAX_DIM-1][0:MAX_DIM-1][ELEM_W-1:0] matrix_t;

    state_t              state_q, state_d;
    logic [2:0]          rows_q, rows_d;
    logic [2:0]          cols_q, cols_d;
    logic [1:0]          id_q, id_d;
    matrix_t             data_q, data_d;
    logic [4:0]          count_q, count_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                mem_err_q, mem_err_d;
    logic                write_en_q, write_en_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                params_ok;
    logic                last_col;
    logic                last_row;

    // Parameter legality for a start request: dims in 1..MAX_DIM, id in 0..1.
    always_comb begin
        params_ok = (rows_in_i != 3'd0) && (rows_in_i <= DIM_MAX) &&
                    (cols_in_i != 3'd0) && (cols_in_i <= DIM_MAX) &&
                    (id_in_i <= ID_MAX);
    end

    // Position of the element being written relative to the latched dims.
    always_comb begin
        last_col = (col_q == (cols_q - 3'd1));
        last_row = (row_q == (rows_q - 3'd1));
    end

    // Next-state and next-output logic for the load sequence.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        id_d       = id_q;
        data_d     = data_q;
        count_d    = count_q;
        row_d      = row_q;
        col_d      = col_q;
        wait_d     = wait_q;
        mem_err_d  = mem_err_q;
        write_en_d = write_en_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (params_ok) begin
                        // A fresh load starts from an all-zero buffer so that
                        // positions outside rows x cols read back as 0.
                        rows_d  = rows_in_i;
                        cols_d  = cols_in_i;
                        id_d    = id_in_i;
                        data_d  = '0;
                        count_d = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_COLLECT;
                    end else begin
                        // Rejected request: latched values stay untouched.
                        error_d = 1'b1;
                    end
                end
            end

            S_COLLECT: begin
                if (abort_i) begin
                    // Abort wins over an element offered in the same cycle.
                    state_d = S_IDLE;
                end else if (elem_valid_i) begin
                    data_d[row_q][col_q] = elem_data_i;
                    count_d = count_q + 5'd1;
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d    = S_WRITE;
                            write_en_d = 1'b1;
                            wait_d     = '0;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end

            S_WRITE: begin
                if (mem_ready_i) begin
                    // Capture the storage verdict now; it is reported once
                    // storage has gone back to idle.
                    mem_err_d  = mem_error_i;
                    write_en_d = 1'b0;
                    state_d    = S_RELEASE;
                end else if (wait_q == WAIT_LAST) begin
                    write_en_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_RELEASE: begin
                // Storage drops ready after seeing write_en low.
                if (!mem_ready_i) begin
                    done_d  = ~mem_err_q;
                    error_d = mem_err_q;
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                write_en_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            id_q       <= '0;
            data_q     <= '0;
            count_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wait_q     <= '0;
            mem_err_q  <= 1'b0;
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            id_q       <= id_d;
            data_q     <= data_d;
            count_q    <= count_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wait_q     <= wait_d;
            mem_err_q  <= mem_err_d;
            write_en_q <= write_en_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Output mapping; ready and busy are straight decodes of the state register.
    always_comb begin
        elem_ready_o = (state_q == S_COLLECT);
        busy_o       = (state_q != S_IDLE);
        write_en_o   = write_en_q;
        rows_out_o   = rows_q;
        cols_out_o   = cols_q;
        mat_id_out_o = id_q;
        data_out_o   = data_q;
        elem_count_o = count_q;
        done_o       = done_q;
        error_o      = error_q;
    end

endmodule

// File: tb/tb_matrix_input_loader.sv
// tb_matrix_input_loader
// Self-checking bench: parameter-legality table, directed multi-cycle loads,
// abort / storage-error / timeout / mid-write reset sequences and randomized
// loads, all checked against a row-major reference model of the buffer.

module tb_matrix_input_loader;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 4;
  localparam int TIMEOUT = 255;
  localparam int LOAD_BUDGET = 600;

  localparam int M_OK    = 0;
  localparam int M_ERR   = 1;
  localparam int M_NEVER = 2;

  typedef logic [0:MAX_DIM-1][0:MAX_DIM-1][ELEM_W-1:0] mat_t;

  typedef struct {
    int r;
    int c;
    int id;
    bit exp_err;
    bit exp_busy;
  } pvec_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [2:0]        rows_in;
  logic [2:0]        cols_in;
  logic [1:0]        id_in;
  logic              elem_valid;
  logic [ELEM_W-1:0] elem_data;
  logic              elem_ready;
  logic              write_en;
  logic [2:0]        rows_out;
  logic [2:0]        cols_out;
  logic [1:0]        mat_id_out;
  mat_t              data_out;
  logic              mem_ready;
  logic              mem_error;
  logic [4:0]        elem_count;
  logic              busy;
  logic              done;
  logic              error;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_mode = M_OK;
  int st_cnt = 0;
  logic [ELEM_W-1:0] elems [25];

  matrix_input_loader #(
    .MAX_DIM(MAX_DIM),
    .ELEM_W (ELEM_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .rows_in_i   (rows_in),
    .cols_in_i   (cols_in),
    .id_in_i     (id_in),
    .elem_valid_i(elem_valid),
    .elem_data_i (elem_data),
    .elem_ready_o(elem_ready),
    .write_en_o  (write_en),
    .rows_out_o  (rows_out),
    .cols_out_o  (cols_out),
    .mat_id_out_o(mat_id_out),
    .data_out_o  (data_out),
    .mem_ready_i (mem_ready),
    .mem_error_i (mem_error),
    .elem_count_o(elem_count),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: IDLE -> WRITE -> DONE, ready 3 cycles after write_en rises,
  // held until write_en drops. M_ERR flags an error, M_NEVER never answers.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      mem_error = 1'b0;
      st_cnt = 0;
    end else if (write_en) begin
      if (mem_mode != M_NEVER) begin
        st_cnt++;
        if (st_cnt >= 3) begin
          mem_ready = 1'b1;
          mem_error = (mem_mode == M_ERR);
        end
      end
    end else begin
      mem_ready = 1'b0;
      mem_error = 1'b0;
      st_cnt = 0;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference buffer: zero matrix, first n stream elements placed row-major.
  function automatic mat_t model_matrix(input int c, input int n);
    mat_t m;
    m = '0;
    for (int k = 0; k < n; k++) m[k / c][k % c] = elems[k];
    return m;
  endfunction

  // ---------------- driver: one complete load ----------------
  task automatic do_load(input string tag, input int r, input int c, input int id,
                         input int mode, input bit gap, input int abort_at);
    int n;
    int k;
    int cyc;
    int last_acc;
    int we_cyc;
    int we_cnt;
    int n_done;
    int n_err;
    int tail;
    bit ready_after_last;
    n = r * c;
    k = 0;
    cyc = 0;
    last_acc = -1;
    we_cyc = -1;
    we_cnt = 0;
    n_done = 0;
    n_err = 0;
    tail = -1;
    ready_after_last = 1'b0;
    mem_mode = mode;

    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    elem_valid = 1'b0;
    rows_in = 3'(r);
    cols_in = 3'(c);
    id_in = 2'(id);

    while (cyc < LOAD_BUDGET && tail != 0) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      elem_valid = 1'b0;
      elem_data = 4'($urandom);
      // observe
      if (done) n_done++;
      if (error) n_err++;
      if (write_en) begin
        we_cnt++;
        if (we_cyc < 0) we_cyc = cyc;
      end
      if (k == n && last_acc >= 0 && cyc > last_acc && elem_ready) ready_after_last = 1'b1;
      if (tail > 0) tail--;
      else if (tail < 0 && (done || error)) tail = 3;
      // drive
      if (tail < 0) begin
        if (abort_at >= 0 && k == abort_at && elem_ready) begin
          abort = 1'b1;
          elem_valid = 1'b1;
          tail = 4;
        end else if (elem_ready && k < n && (!gap || (cyc % 2) == 1)) begin
          elem_valid = 1'b1;
          elem_data = elems[k];
          k++;
          if (k == n) last_acc = cyc;
        end else if (!elem_ready) begin
          // Noise that must be ignored outside collection.
          elem_valid = 1'($urandom_range(0, 1));
          if (write_en) begin
            start = 1'b1;
            rows_in = 3'($urandom_range(1, 5));
            cols_in = 3'($urandom_range(1, 5));
            id_in = 2'($urandom_range(0, 1));
          end
        end
      end
      cyc++;
    end
    start = 1'b0;
    elem_valid = 1'b0;

    check($sformatf("%s:finished", tag), (tail == 0), 1);
    check($sformatf("%s:busy_end", tag), busy, 1'b0);
    if (abort_at >= 0) begin
      check($sformatf("%s:count", tag), elem_count, abort_at);
      check($sformatf("%s:we_never", tag), we_cyc, -1);
      check($sformatf("%s:done", tag), n_done, 0);
      check($sformatf("%s:err", tag), n_err, 0);
    end else begin
      check($sformatf("%s:count", tag), elem_count, n);
      check($sformatf("%s:data", tag), data_out, model_matrix(c, n));
      check($sformatf("%s:rows", tag), rows_out, r);
      check($sformatf("%s:cols", tag), cols_out, c);
      check($sformatf("%s:id", tag), mat_id_out, id);
      check($sformatf("%s:we_latency", tag), we_cyc, last_acc + 1);
      check($sformatf("%s:ready_low", tag), ready_after_last, 1'b0);
      if (mode == M_OK) begin
        check($sformatf("%s:we_cycles", tag), we_cnt, 3);
        check($sformatf("%s:done", tag), n_done, 1);
        check($sformatf("%s:err", tag), n_err, 0);
      end else if (mode == M_ERR) begin
        check($sformatf("%s:we_cycles", tag), we_cnt, 3);
        check($sformatf("%s:done", tag), n_done, 0);
        check($sformatf("%s:err", tag), n_err, 1);
      end else begin
        check($sformatf("%s:timeout_window", tag),
              (we_cnt >= TIMEOUT - 1 && we_cnt <= TIMEOUT + 1), 1);
        check($sformatf("%s:done", tag), n_done, 0);
        check($sformatf("%s:err", tag), n_err, 1);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    pvec_t tbl [9];
    int exp_rows;
    int exp_cols;
    int exp_id;
    int r;
    int c;

    tbl[0] = '{0, 3, 0, 1'b1, 1'b0};
    tbl[1] = '{3, 6, 0, 1'b1, 1'b0};
    tbl[2] = '{2, 2, 2, 1'b1, 1'b0};
    tbl[3] = '{6, 1, 1, 1'b1, 1'b0};
    tbl[4] = '{5, 5, 3, 1'b1, 1'b0};
    tbl[5] = '{0, 0, 0, 1'b1, 1'b0};
    tbl[6] = '{4, 2, 1, 1'b0, 1'b1};
    tbl[7] = '{5, 5, 0, 1'b0, 1'b1};
    tbl[8] = '{1, 1, 0, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    rows_in = '0;
    cols_in = '0;
    id_in = '0;
    elem_valid = 1'b0;
    elem_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst:elem_ready", elem_ready, 1'b0);
    check("rst:write_en", write_en, 1'b0);
    check("rst:rows", rows_out, 3'd0);
    check("rst:cols", cols_out, 3'd0);
    check("rst:id", mat_id_out, 2'd0);
    check("rst:data", data_out, '0);
    check("rst:count", elem_count, 5'd0);
    check("rst:busy", busy, 1'b0);
    check("rst:done", done, 1'b0);
    check("rst:error", error, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x3, id 0, 1..6 back-to-back
    for (int k = 0; k < 6; k++) elems[k] = 4'(k + 1);
    do_load("2x3", 2, 3, 0, M_OK, 1'b0, -1);
    check("2x3:row0", data_out[0], {4'd1, 4'd2, 4'd3, 4'd0, 4'd0});
    check("2x3:row1", data_out[1], {4'd4, 4'd5, 4'd6, 4'd0, 4'd0});

    // 5x5 with elem_valid every other cycle, values (i*5+j)%16
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) elems[i * 5 + j] = 4'((i * 5 + j) % 16);
    do_load("5x5gap", 5, 5, 1, M_OK, 1'b1, -1);

    // Start-parameter table
    exp_rows = 2'd0 + 5;
    exp_cols = 5;
    exp_id = 1;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      start = 1'b1;
      rows_in = 3'(tbl[t].r);
      cols_in = 3'(tbl[t].c);
      id_in = 2'(tbl[t].id);
      @(negedge clk);
      start = 1'b0;
      if (!tbl[t].exp_err) begin
        exp_rows = tbl[t].r;
        exp_cols = tbl[t].c;
        exp_id = tbl[t].id;
      end
      check($sformatf("tbl%0d:error", t), error, tbl[t].exp_err);
      check($sformatf("tbl%0d:busy", t), busy, tbl[t].exp_busy);
      check($sformatf("tbl%0d:rows", t), rows_out, exp_rows);
      check($sformatf("tbl%0d:cols", t), cols_out, exp_cols);
      check($sformatf("tbl%0d:id", t), mat_id_out, exp_id);
      if (tbl[t].exp_busy) begin
        check($sformatf("tbl%0d:data_clr", t), data_out, '0);
        check($sformatf("tbl%0d:count_clr", t), elem_count, 5'd0);
        abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      check($sformatf("tbl%0d:error_pulse", t), error, 1'b0);
      check($sformatf("tbl%0d:idle", t), busy, 1'b0);
    end

    // 3x3 aborted after 4 elements, then 1x1 of 9
    for (int k = 0; k < 9; k++) elems[k] = 4'(k + 10);
    do_load("abort", 3, 3, 0, M_OK, 1'b0, 4);
    elems[0] = 4'd9;
    do_load("1x1", 1, 1, 1, M_OK, 1'b0, -1);
    begin
      mat_t only9;
      only9 = '0;
      only9[0][0] = 4'd9;
      check("1x1:only9", data_out, only9);
    end

    // Storage error, then storage that never answers
    for (int k = 0; k < 4; k++) elems[k] = 4'($urandom);
    do_load("memerr", 2, 2, 1, M_ERR, 1'b0, -1);
    for (int k = 0; k < 2; k++) elems[k] = 4'($urandom);
    do_load("timeout", 1, 2, 0, M_NEVER, 1'b0, -1);

    // Asynchronous reset while in WRITE
    mem_mode = M_NEVER;
    @(negedge clk);
    start = 1'b1;
    rows_in = 3'd1;
    cols_in = 3'd1;
    id_in = 2'd1;
    @(negedge clk);
    start = 1'b0;
    elem_valid = 1'b1;
    elem_data = 4'd7;
    @(negedge clk);
    elem_valid = 1'b0;
    check("rstw:write_en_pre", write_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw:write_en", write_en, 1'b0);
    check("rstw:data", data_out, '0);
    check("rstw:busy", busy, 1'b0);
    check("rstw:rows", rows_out, 3'd0);
    check("rstw:id", mat_id_out, 2'd0);
    check("rstw:count", elem_count, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw:idle_after", busy, 1'b0);
    for (int k = 0; k < 6; k++) elems[k] = 4'($urandom);
    do_load("after_rst", 3, 2, 0, M_OK, 1'b0, -1);

    // Randomized loads
    for (int t = 0; t < 20; t++) begin
      r = $urandom_range(1, 5);
      c = $urandom_range(1, 5);
      for (int k = 0; k < 25; k++) elems[k] = 4'($urandom);
      do_load($sformatf("rand%0d", t), r, c, $urandom_range(0, 1),
              ($urandom_range(0, 4) == 0) ? M_ERR : M_OK, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
